// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment driver: segment codes (gfedcba, active-low),
// irrigation mode codes, conversion FSM encoding and segment lookup helpers.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_G     = 7'h42;
   localparam logic [6:0] SEG_E     = 7'h06;

   localparam logic [1:0] MODE_BLANK = 2'b00;
   localparam logic [1:0] MODE_A     = 2'b01;
   localparam logic [1:0] MODE_G     = 2'b10;
   localparam logic [1:0] MODE_E     = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   function automatic logic [6:0] seg_digit(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   function automatic logic [6:0] seg_mode(input logic [1:0] m);
      logic [6:0] s;
      case (m)
         MODE_A:     s = SEG_A;
         MODE_G:     s = SEG_G;
         MODE_E:     s = SEG_E;
         MODE_BLANK: s = SEG_BLANK;
         default:    s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to 10-bit BCD, one shift per cycle after start.
// done is high during the eighth (final) shift cycle; bcd is valid the cycle after.
module bin2bcd_seq (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] bin,
   output logic       busy,
   output logic       done,
   output logic [9:0] bcd
);

   logic [7:0] r_bin;
   logic [9:0] r_bcd;
   logic [2:0] r_cnt;
   logic       r_busy;
   logic [3:0] w_units;
   logic [3:0] w_tens;

   // Hundreds never reaches 5 for an 8-bit input, so only tens and units need correction.
   assign w_units = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
   assign w_tens  = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bin  <= '0;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (start) begin
         r_bin  <= bin;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_bcd  <= {r_bcd[8], w_tens, w_units, r_bin[7]};
         r_bin  <= {r_bin[6:0], 1'b0};
         r_cnt  <= r_cnt + 3'd1;
         if (r_cnt == 3'd7)
            r_busy <= 1'b0;
      end
   end

   assign busy = r_busy;
   assign done = r_busy && (r_cnt == 3'd7);
   assign bcd  = r_bcd;

endmodule

// File: rtl/display7seg_driver.sv
// Converts a captured value/mode to BCD (done 9 cycles after load) and scans four
// multiplexed digits on synchronised tick edges, with one blank cycle between digits.
module display7seg_driver
   import seg7_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic [7:0] value,
   input  logic [1:0] mode,
   input  logic       load,
   output logic       busy,
   output logic       done,
   output logic [6:0] seg,
   output logic [3:0] an
);

   logic       r_tick_s1, r_tick_s2, r_tick_s3;
   logic       w_scan_en;
   state_e     r_state, w_state_nxt;
   logic       w_start, w_commit;
   logic       w_bcd_busy, w_bcd_done;
   logic [9:0] w_bcd;
   logic [1:0] r_mode_cap;
   logic       r_disp_vld;
   logic [1:0] r_disp_mode;
   logic [9:0] r_disp_bcd;
   logic [1:0] r_idx, r_show;
   logic       r_started;
   logic [6:0] r_seg, w_seg_nxt;
   logic [3:0] r_an;
   logic [1:0] w_h;
   logic [3:0] w_t, w_u;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tick_s1 <= 1'b0;
         r_tick_s2 <= 1'b0;
         r_tick_s3 <= 1'b0;
      end else begin
         r_tick_s1 <= tick;
         r_tick_s2 <= r_tick_s1;
         r_tick_s3 <= r_tick_s2;
      end
   end

   assign w_scan_en = r_tick_s2 & ~r_tick_s3;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (load) begin
               w_start     = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_bcd_done)
               w_state_nxt = ST_COMMIT;
         end
         ST_COMMIT: begin
            w_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .reset (reset),
      .start (w_start),
      .bin   (value),
      .busy  (w_bcd_busy),
      .done  (w_bcd_done),
      .bcd   (w_bcd)
   );

   // The converter is busy exactly across SHIFT, so adding COMMIT covers all 9 cycles.
   assign busy = w_bcd_busy | (r_state == ST_COMMIT);
   assign done = w_commit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode_cap  <= MODE_BLANK;
         r_disp_vld  <= 1'b0;
         r_disp_mode <= MODE_BLANK;
         r_disp_bcd  <= '0;
      end else begin
         if (w_start)
            r_mode_cap <= mode;
         if (w_commit) begin
            r_disp_vld  <= 1'b1;
            r_disp_mode <= r_mode_cap;
            r_disp_bcd  <= w_bcd;
         end
      end
   end

   assign w_h = r_disp_bcd[9:8];
   assign w_t = r_disp_bcd[7:4];
   assign w_u = r_disp_bcd[3:0];

   always_comb begin
      w_seg_nxt = SEG_BLANK;
      if (r_disp_vld) begin
         case (r_show)
            2'd0: w_seg_nxt = seg_digit(w_u);
            2'd1: if (w_h != 2'd0 || w_t != 4'd0) w_seg_nxt = seg_digit(w_t);
            2'd2: if (w_h != 2'd0) w_seg_nxt = seg_digit({2'b00, w_h});
            default: w_seg_nxt = seg_mode(r_disp_mode);
         endcase
      end
   end

   // Each scan_en latches the digit to show next and blanks the outputs for one cycle;
   // the digit is re-evaluated every cycle after that so a coincident commit shows at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx     <= 2'd0;
         r_show    <= 2'd0;
         r_started <= 1'b0;
         r_seg     <= SEG_BLANK;
         r_an      <= 4'hF;
      end else if (w_scan_en) begin
         r_show    <= r_idx;
         r_idx     <= r_idx + 2'd1;
         r_started <= 1'b1;
         r_seg     <= SEG_BLANK;
         r_an      <= 4'hF;
      end else if (r_started) begin
         r_seg <= w_seg_nxt;
         r_an  <= ~(4'b0001 << r_show);
      end
   end

   assign seg = r_seg;
   assign an  = r_an;

endmodule

// File: tb/tb_display7seg_driver.sv
// Self-checking bench for display7seg_driver: directed steps plus random values,
// checked against an arithmetic digit/scan model.
module tb_display7seg_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic [7:0] value;
   logic [1:0] mode;
   logic       load;
   logic       busy;
   logic       done;
   logic [6:0] seg;
   logic [3:0] an;

   int checks = 0;
   int errors = 0;
   int scan_cnt = 0;
   int m_val = 0;
   int m_mode = 0;
   bit m_vld = 1'b0;

   logic [6:0] dig_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   logic [6:0] mode_tab [0:3] = '{7'h7F, 7'h08, 7'h42, 7'h06};

   always #5 clk = ~clk;

   display7seg_driver dut (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .value (value),
      .mode  (mode),
      .load  (load),
      .busy  (busy),
      .done  (done),
      .seg   (seg),
      .an    (an)
   );

   function automatic logic [6:0] ref_seg(input int idx);
      int u, t, h;
      u = m_val % 10;
      t = (m_val / 10) % 10;
      h = m_val / 100;
      if (!m_vld) return 7'h7F;
      case (idx)
         0: return dig_tab[u];
         1: return (h == 0 && t == 0) ? 7'h7F : dig_tab[t];
         2: return (h == 0) ? 7'h7F : dig_tab[h];
         default: return mode_tab[m_mode];
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int v, input int m);
      value = 8'(v);
      mode  = 2'(m);
      load  = 1'b1;
      step;
      load = 1'b0;
      for (int n = 0; n < 8; n++) begin
         chk("shift_busy", 32'(busy), 32'd1);
         chk("shift_done", 32'(done), 32'd0);
         step;
      end
      chk("commit_done", 32'(done), 32'd1);
      chk("commit_busy", 32'(busy), 32'd1);
      step;
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      m_val  = v;
      m_mode = m;
      m_vld  = 1'b1;
   endtask

   task automatic do_scan;
      int idx;
      logic [3:0] exp_an;
      idx    = scan_cnt % 4;
      exp_an = ~(4'b0001 << idx);
      tick = 1'b1;
      step;
      step;
      step;
      chk("ghost_an", 32'(an), 32'hF);
      chk("ghost_seg", 32'(seg), 32'h7F);
      step;
      chk("digit_an", 32'(an), 32'(exp_an));
      chk("digit_seg", 32'(seg), 32'(ref_seg(idx)));
      tick = 1'b0;
      scan_cnt++;
      step;
      step;
      step;
   endtask

   initial begin
      int dones;
      int blanks;
      int dir_vals [0:4];
      logic [3:0] exp_an;

      dir_vals = '{0, 9, 10, 99, 200};
      reset = 1'b1;
      tick  = 1'b0;
      value = 8'd0;
      mode  = 2'd0;
      load  = 1'b0;
      step;
      step;
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step;
         chk("post_rst_an", 32'(an), 32'hF);
      end

      do_load(255, 1);
      for (int i = 0; i < 4; i++) do_scan;

      do_load(7, 0);
      for (int i = 0; i < 4; i++) do_scan;

      // Second load lands while busy and must be dropped.
      value = 8'd100;
      mode  = 2'd3;
      load  = 1'b1;
      step;
      load  = 1'b0;
      dones = 0;
      step;
      step;
      value = 8'd42;
      mode  = 2'd2;
      load  = 1'b1;
      step;
      load  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) dones++;
         step;
      end
      chk("ignored_load_dones", 32'(dones), 32'd1);
      m_val  = 100;
      m_mode = 3;
      m_vld  = 1'b1;
      for (int i = 0; i < 4; i++) do_scan;

      for (int i = 0; i < 5; i++) begin
         do_load(dir_vals[i], i % 4);
         for (int j = 0; j < 4; j++) do_scan;
      end

      for (int i = 0; i < 6; i++) begin
         do_load(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
         for (int j = 0; j < 4; j++) do_scan;
      end

      // Reset four cycles into SHIFT aborts the conversion.
      value = 8'd200;
      mode  = 2'd2;
      load  = 1'b1;
      step;
      load = 1'b0;
      step;
      step;
      step;
      reset = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_an", 32'(an), 32'hF);
      chk("abort_seg", 32'(seg), 32'h7F);
      step;
      reset    = 1'b0;
      m_vld    = 1'b0;
      scan_cnt = 0;
      dones    = 0;
      for (int i = 0; i < 15; i++) begin
         if (done === 1'b1) dones++;
         step;
      end
      chk("abort_no_done", 32'(dones), 32'd0);
      chk("abort_an_idle", 32'(an), 32'hF);
      for (int i = 0; i < 4; i++) do_scan;

      // A long tick high must advance the scan exactly once.
      do_load(58, 3);
      do_scan;
      tick   = 1'b1;
      blanks = 0;
      for (int i = 0; i < 50; i++) begin
         step;
         if (an === 4'hF) blanks++;
      end
      exp_an = ~(4'b0001 << (scan_cnt % 4));
      chk("held_tick_blanks", 32'(blanks), 32'd1);
      chk("held_tick_an", 32'(an), 32'(exp_an));
      chk("held_tick_seg", 32'(seg), 32'(ref_seg(scan_cnt % 4)));
      scan_cnt++;
      tick = 1'b0;
      step;
      step;
      step;
      do_scan;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/display7seg_driver.md
DISPLAY7SEG_DRIVER -- requirements
Module: display7seg_driver

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic is on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port tick, input, 1, divided scan clock from the divider; treated as data, never as a clock.
REQ-004 SHALL have port value, input, 8, unsigned binary to display (0-255).
REQ-005 SHALL have port mode, input, 2, irrigation mode code: 00 blank, 01 'A', 10 'G', 11 'E'.
REQ-006 SHALL have port load, input, 1, request to capture value/mode; sampled only when busy=0.
REQ-007 SHALL have port busy, output, 1, conversion in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when the new digits are committed.
REQ-009 SHALL have port seg, output, 7, segments gfedcba, active-low.
REQ-010 SHALL have port an, output, 4, digit enables, active-low, an[0] = rightmost digit.

Function
REQ-011 SHALL synchronise tick through two flops and form scan_en as a one-cycle pulse on each synchronised rising edge; a tick held high SHALL produce exactly one scan_en.
REQ-012 SHALL run the conversion FSM with states IDLE, SHIFT and COMMIT.
REQ-013 IDLE: when load=1, SHALL capture value and mode and go to SHIFT.
REQ-014 SHALL run SHIFT for exactly 8 cycles of shift-and-add-3 double-dabble into 10-bit BCD (hundreds 2b, tens 4b, units 4b), then go to COMMIT.
REQ-015 COMMIT: SHALL write the BCD digits and mode to the display register, assert done for that cycle, and return to IDLE.
REQ-016 busy SHALL be 1 in SHIFT and COMMIT (9 cycles); a load sampled at edge k SHALL give done=1 in cycle k+9, with the new digits displayed from cycle k+10.
REQ-017 load while busy=1 SHALL be ignored, not queued.
REQ-018 SHALL keep a 2-bit scan index that increments on each scan_en and wraps from 3 to 0.
REQ-019 Digit mapping SHALL be: index 0 units (always shown), index 1 tens, index 2 hundreds, index 3 mode letter.
REQ-020 Leading-zero blanking SHALL apply: hundreds blank if 0; tens blank if hundreds=0 and tens=0.
REQ-021 Segment codes SHALL be: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, 'A'=0x08, 'G'=0x42, 'E'=0x06, blank=0x7F.
REQ-022 Anti-ghost: in the cycle after scan_en, seg SHALL be 0x7F and an SHALL be 0xF; from the following cycle the new digit SHALL be driven (an one-hot low at the index).
REQ-023 seg and an SHALL be registered outputs.
REQ-024 A COMMIT coinciding with scan_en SHALL show the new data on the digit being selected.

Reset
REQ-025 On reset: seg=0x7F, an=0xF, busy=0, done=0, FSM=IDLE, scan index=0, display register blank (mode=00, all digits blanked), synchroniser flops=0.
REQ-026 Reset during SHIFT SHALL abort the conversion with no done and no display update.
REQ-027 an SHALL stay 0xF after reset until the first scan_en.

Structure
REQ-028 Package seg7_pkg SHALL hold the segment constants, the mode code values and the FSM state encoding.
REQ-029 Sub-module bin2bcd_seq SHALL implement the sequential double-dabble (start, busy, done, bcd).

Verification
REQ-030 Reset asserted -> seg=0x7F, an=0xF, busy=0, done=0.
REQ-031 load value=255, mode=01 at edge k -> done at k+9; next four scan_en -> an 1110/1101/1011/0111 with seg 0x12/0x12/0x24/0x08, each preceded by one blank cycle.
REQ-032 value=7, mode=00 -> digit0 0x78; digits 1, 2 and 3 all 0x7F.
REQ-033 load 100, then load 42 three cycles later -> single done; display shows 1,0,0.
REQ-034 reset pulse at cycle 4 of SHIFT -> busy=0 at once, no done, display blank.
REQ-035 tick held high for 50 cycles -> exactly one scan index advance.
